// File: rtl/morse_tx_encoder.sv
// Morse transmit keyer: turns one latched element pattern (or a word-space request) into timed on/off keying.
// Latency: light rises on the accept edge; done pulses for the first IDLE cycle; start is accepted only while ready.
module morse_tx_encoder #(
  parameter int UNIT_TICKS = 2,
  parameter int MAX_LEN    = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic       is_space,
  input  logic [2:0] symbol_len,
  input  logic [4:0] symbol_bits,
  output logic       light,
  output logic       ready,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int TW = (UNIT_TICKS > 1) ? $clog2(UNIT_TICKS) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MARK     = 3'd1,
    ELEM_GAP = 3'd2,
    CHAR_GAP = 3'd3,
    WORD_GAP = 3'd4
  } state_t;

  state_t        state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    unit_cnt;
  logic [2:0]    idx;
  logic [4:0]    cur_bits;
  logic [2:0]    phase_units;
  logic          last_tick;
  logic          phase_end;
  logic          len_ok;

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  assign len_ok = (symbol_len != 3'd0) && (symbol_len <= 3'(MAX_LEN));

  // Length of the current phase in Morse units.
  always_comb begin
    phase_units = 3'd1;
    case (state)
      MARK:     phase_units = cur_bits[idx] ? 3'd3 : 3'd1;
      ELEM_GAP: phase_units = 3'd1;
      CHAR_GAP: phase_units = 3'd3;
      WORD_GAP: phase_units = 3'd7;
      default:  phase_units = 3'd1;
    endcase
  end

  assign last_tick = tick && (tick_cnt == TW'(UNIT_TICKS - 1));
  assign phase_end = last_tick && (unit_cnt == phase_units - 3'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      light    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tick_cnt <= '0;
      unit_cnt <= '0;
      idx      <= '0;
      cur_bits <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (state == IDLE) begin
        // Ticks seen while idle (including the accept edge) never count.
        tick_cnt <= '0;
        unit_cnt <= '0;
        if (start) begin
          if (is_space) begin
            state <= WORD_GAP;
          end else if (len_ok) begin
            cur_bits <= symbol_bits;
            idx      <= symbol_len - 3'd1;
            state    <= MARK;
            light    <= 1'b1;
          end else begin
            err <= 1'b1;
          end
        end
      end else if (tick) begin
        if (phase_end) begin
          tick_cnt <= '0;
          unit_cnt <= '0;
          case (state)
            MARK: begin
              light <= 1'b0;
              state <= (idx != 3'd0) ? ELEM_GAP : CHAR_GAP;
            end
            ELEM_GAP: begin
              idx   <= idx - 3'd1;
              light <= 1'b1;
              state <= MARK;
            end
            CHAR_GAP, WORD_GAP: begin
              state <= IDLE;
              done  <= 1'b1;
            end
            default: state <= IDLE;
          endcase
        end else if (last_tick) begin
          tick_cnt <= '0;
          unit_cnt <= unit_cnt + 3'd1;
        end else begin
          tick_cnt <= tick_cnt + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_morse_tx_encoder.sv
// Bench for morse_tx_encoder: keying runs are measured in tick pulses and matched against a unit-timing model.
module tb_morse_tx_encoder;

  localparam int U = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b1;
  logic       start = 1'b0;
  logic       is_space = 1'b0;
  logic [2:0] symbol_len = '0;
  logic [4:0] symbol_bits = '0;
  logic       light, ready, busy, done, err;

  int tests = 0;
  int fails = 0;
  int tick_mode = 0;
  string exp_q[$];

  morse_tx_encoder #(.UNIT_TICKS(U), .MAX_LEN(5)) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick), .start(start), .is_space(is_space),
    .symbol_len(symbol_len), .symbol_bits(symbol_bits),
    .light(light), .ready(ready), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Tick strobe: tied high, every third cycle, or random.
  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tc++;
      case (tick_mode)
        0:       tick = 1'b1;
        1:       tick = (tc % 3 == 0);
        default: tick = 1'($urandom_range(0, 1));
      endcase
    end
  end

  function automatic string model(input bit sp, input int len, input logic [4:0] bits);
    string s;
    if (sp) return $sformatf("L%0d ", 7 * U);
    if (len < 1 || len > 5) return "ERR";
    s = "";
    for (int i = len - 1; i >= 0; i--) begin
      s = {s, $sformatf("H%0d ", (bits[i] ? 3 : 1) * U)};
      s = {s, $sformatf("L%0d ", ((i > 0) ? 1 : 3) * U)};
    end
    return s;
  endfunction

  task automatic check(input string name, input logic act, input logic req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %b, expected %b", name, act, req);
    end
  endtask

  task automatic score(input string act);
    string e;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_output: got '%s', expected nothing", act);
    end else begin
      e = exp_q.pop_front();
      if (e != act) begin
        fails++;
        $display("FAIL keying: got '%s', expected '%s'", act, e);
      end
    end
  endtask

  // Monitor: measures each mark/space run in counted ticks, closes the record on done.
  initial begin
    bit    in_txn;
    logic  lvl;
    int    cnt;
    string seg;
    in_txn = 0; lvl = 0; cnt = 0; seg = "";
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        in_txn = 0;
      end else begin
        if (err) score((busy || done) ? "ERR_BAD" : "ERR");
        if (busy) begin
          if (!in_txn) begin
            in_txn = 1; seg = ""; lvl = light; cnt = 0;
          end else if (light !== lvl) begin
            seg = {seg, $sformatf("%s%0d ", lvl ? "H" : "L", cnt)};
            lvl = light; cnt = 0;
          end
          if (tick) cnt++;
        end
        if (done) begin
          if (in_txn) seg = {seg, $sformatf("%s%0d ", lvl ? "H" : "L", cnt)};
          else seg = "NOBUSY";
          if (light !== 1'b0 || !ready) seg = {seg, "BADIDLE"};
          in_txn = 0;
          score(seg);
        end
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 2000 && !ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!ready) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: ready=%b, expected 1", ready);
    end
  endtask

  task automatic send(input bit sp, input logic [2:0] len, input logic [4:0] bits);
    wait_ready();
    start = 1'b1; is_space = sp; symbol_len = len; symbol_bits = bits;
    exp_q.push_back(model(sp, int'(len), bits));
    @(posedge clk);
    #1;
    start = 1'b0;
    symbol_len = 3'($urandom); symbol_bits = 5'($urandom); is_space = 1'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: %0d outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_light", light, 1'b0);
    check("reset_ready", ready, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done_err", done | err, 1'b0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Single dot, then dot-dash with a five-dash character issued in its done cycle.
    send(0, 3'd1, 5'b00000);
    send(0, 3'd2, 5'b00001);
    wait_ready();
    check("b2b_in_done_cycle", done, 1'b1);
    send(0, 3'd5, 5'b11111);
    #1;
    check("b2b_busy_next", busy, 1'b1);

    // Word space, with a zero length that must not raise err.
    send(1, 3'd0, 5'b00000);
    // Invalid lengths.
    send(0, 3'd0, 5'b10101);
    send(0, 3'd6, 5'b10101);
    send(0, 3'd7, 5'b00000);
    #1;
    check("reject_busy", busy, 1'b0);

    // A start pulse while busy must be ignored.
    send(0, 3'd2, 5'b00001);
    repeat (3) @(posedge clk);
    #1;
    check("busy_mid_A", busy, 1'b1);
    start = 1'b1; symbol_len = 3'd3; symbol_bits = 5'b00111;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // Sparse ticks.
    tick_mode = 1;
    send(0, 3'd1, 5'b00000);
    send(0, 3'd3, 5'b00101);
    drain();

    // Reset abort in the middle of a dash.
    tick_mode = 0;
    send(0, 3'd1, 5'b00001);
    repeat (2) @(posedge clk);
    #2;
    check("pre_abort_light", light, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_light", light, 1'b0);
    check("abort_ready", ready, 1'b1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("no_done_after_abort", ready, 1'b1);
    send(0, 3'd1, 5'b00000);
    drain();

    // Randomized traffic under random ticks.
    tick_mode = 2;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) send(1, 3'($urandom), 5'($urandom));
      else send(0, 3'($urandom), 5'($urandom));
    end
    drain();
    check("final_ready", ready, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/morse_tx_encoder.md
Name: morse_tx_encoder

Overview:
- Transmit direction of the Morse translator. Converts one latched character pattern, or a word-space request, into on/off keying on a single `light` output with standard Morse timing.
- Sits between the character-to-pattern lookup and the LED/buzzer driver.
- Timing base is an external `tick` strobe, the same divided-clock enable the timing logic uses elsewhere.

Parameters:
UNIT_TICKS, 2, number of tick pulses per Morse time unit (>=1)
MAX_LEN, 5, maximum elements per character (fixed; bit widths below assume 5)

Ports:
clk  input  1  system clock, all logic on posedge
reset_n  input  1  asynchronous active-low reset
tick  input  1  timing strobe; one-cycle pulse, may be tied high
start  input  1  request to send; sampled only when ready=1
is_space  input  1  with start: send word gap; symbol_len/symbol_bits ignored
symbol_len  input  3  element count, valid 1..5
symbol_bits  input  5  element pattern; 1=dash, 0=dot; bit[symbol_len-1] sent first, bit[0] last
light  output  1  keyed output, 1 = mark
ready  output  1  1 when idle and able to accept start
busy  output  1  ~ready
done  output  1  one-cycle pulse when a character or space completes
err  output  1  one-cycle pulse when start is rejected for invalid length

Behaviour:
- Reset (async, reset_n=0): state=IDLE, light=0, ready=1, busy=0, done=0, err=0, all counters 0. Takes effect immediately, including mid-character. No partial output resumes after release.
- Timing, in units: dot = 1 unit mark; dash = 3 units mark; intra-character gap = 1 unit space; gap after the last element = 3 units; word space = 7 units.
- FSM states:
  - IDLE: ready=1, light=0.
  - MARK: light=1.
  - ELEM_GAP: light=0.
  - CHAR_GAP: light=0.
  - WORD_GAP: light=0.
- Accept: at a posedge with state=IDLE and start=1:
  - is_space=1: go to WORD_GAP.
  - Else if symbol_len in 1..5: latch len/bits, element index = len-1, go to MARK. light=1 from that edge.
  - Else (len 0, 6, 7): stay IDLE, err=1 for exactly the next cycle.
  - A tick coincident with the accept edge is not counted.
- Phase timing:
  - Each phase lasts exactly duration×UNIT_TICKS tick pulses.
  - The transition, and the light change, happen at the posedge that samples the final counted tick.
  - tick_cnt and unit_cnt clear on every phase entry.
- Transitions:
  - MARK → ELEM_GAP if element index > 0; MARK → CHAR_GAP if index = 0.
  - ELEM_GAP → MARK, decrementing the index.
  - CHAR_GAP → IDLE and WORD_GAP → IDLE, with done=1 for exactly the first IDLE cycle.
- Back-to-back: start may be asserted during the done cycle. It is accepted there, so light may rise in the cycle after done. There are no extra idle cycles beyond that.
- start while busy=1 is ignored: no latch, no err. symbol inputs are don't-care outside the accept edge.
- Holding start high issues a new character each time IDLE is reached.
- done and err never assert together. done never asserts after a reset abort.
- Counter widths must hold 7×UNIT_TICKS−1 without wrap.

Test Plan:
1. tick=1, UNIT_TICKS=2; 'E' (len=1, bits=00000) → light high 2 cycles after the accept edge, then low 6. busy for 8 cycles. done pulse 1 cycle. ready=1 afterwards.
2. 'A' (len=2, bits=00001) → light pattern H2 L2 H6 L6, busy 16 cycles, one done. Then '0' (len=5, bits=11111) started in the done cycle → (H6 L2)×4, H6, L6 = 44 busy cycles with no idle cycle between characters.
3. is_space=1 with start → light stays 0 for 14 cycles, then done. With symbol_len=0 plus is_space, no err.
4. start with symbol_len=0, then 6 → err pulse each time, light=0, busy stays 0. start asserted mid-'A' → ignored, pattern unchanged, exactly one done.
5. tick every 3rd cycle, UNIT_TICKS=2, 'E' → light high until the edge sampling the 2nd tick after accept. Total busy spans 8 tick pulses. Counts are unaffected by non-tick cycles.
6. reset_n pulsed low mid-dash of 'T' (len=1, bits=1) → light=0, ready=1 immediately (asynchronous, no clock edge needed). No done. A fresh 'E' after release has nominal timing.
